// File: rtl/vt52_pkg.sv
// vt52_pkg: default geometry and the scroll state encoding shared by the scroll engine.
`timescale 1ns/1ps
`default_nettype none

package vt52_pkg;

  localparam int          DEF_ROWS      = 24;
  localparam int          DEF_COLS      = 80;
  localparam int          DEF_ADDR_BITS = 11;
  localparam logic [7:0]  DEF_FILL_CHAR = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COPY  = 2'd1,
    ST_CLEAR = 2'd2,
    ST_DONE  = 2'd3
  } scroll_state_t;

endpackage

`default_nettype wire

// File: rtl/scroll_addr_gen.sv
// scroll_addr_gen: copy destination/source and clear address counters for up or down scrolls.
`timescale 1ns/1ps
`default_nettype none

module scroll_addr_gen
  import vt52_pkg::*;
#(
  parameter int ROWS      = DEF_ROWS,
  parameter int COLS      = DEF_COLS,
  parameter int ADDR_BITS = DEF_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 dir,
  input  logic                 copy_step,
  input  logic                 clear_step,
  output logic [ADDR_BITS-1:0] copy_dst,
  output logic [ADDR_BITS-1:0] copy_src,
  output logic                 copy_last,
  output logic [ADDR_BITS-1:0] clear_addr,
  output logic                 clear_last
);

  localparam logic [ADDR_BITS-1:0] LAST_ADDR   = ADDR_BITS'(ROWS*COLS - 1);
  localparam logic [ADDR_BITS-1:0] COPY_UP_END = ADDR_BITS'((ROWS-1)*COLS - 1);
  localparam logic [ADDR_BITS-1:0] CLR_UP_BASE = ADDR_BITS'((ROWS-1)*COLS);
  localparam logic [ADDR_BITS-1:0] COLS_A      = ADDR_BITS'(COLS);
  localparam logic [ADDR_BITS-1:0] COLS_M1     = ADDR_BITS'(COLS - 1);

  logic                 down;
  logic [ADDR_BITS-1:0] dst;
  logic [ADDR_BITS-1:0] clr;

  // Counters hold at their terminal value, so they cannot run past the buffer or wrap below 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      down <= 1'b0;
      dst  <= '0;
      clr  <= '0;
    end else if (start) begin
      down <= dir;
      dst  <= dir ? LAST_ADDR : '0;
      clr  <= dir ? COLS_M1 : CLR_UP_BASE;
    end else begin
      if (copy_step && !copy_last)
        dst <= down ? dst - 1'b1 : dst + 1'b1;
      if (clear_step && !clear_last)
        clr <= down ? clr - 1'b1 : clr + 1'b1;
    end
  end

  assign copy_dst   = dst;
  assign copy_src   = down ? dst - COLS_A : dst + COLS_A;
  assign copy_last  = down ? (dst == COLS_A) : (dst == COPY_UP_END);
  assign clear_addr = clr;
  assign clear_last = down ? (clr == '0) : (clr == LAST_ADDR);

endmodule

`default_nettype wire

// File: rtl/scroll_engine.sv
// scroll_engine: moves the character buffer one row up (or down with SCROLL_ENGINE_DOWN_EN)
// using a pipelined read/write copy followed by a fill of the vacated row.
`timescale 1ns/1ps
`default_nettype none

module scroll_engine
  import vt52_pkg::*;
#(
  parameter int         ROWS      = DEF_ROWS,
  parameter int         COLS      = DEF_COLS,
  parameter int         ADDR_BITS = DEF_ADDR_BITS,
  parameter logic [7:0] FILL_CHAR = DEF_FILL_CHAR
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 scroll_req,
  input  logic                 scroll_dir,
  output logic                 scroll_busy,
  output logic                 scroll_done,
  output logic                 scroll_ovr,
  output logic [ADDR_BITS-1:0] mem_rd_addr,
  input  logic [7:0]           mem_rd_data,
  output logic [ADDR_BITS-1:0] mem_wr_addr,
  output logic [7:0]           mem_wr_data,
  output logic                 mem_wr_en
);

  scroll_state_t        state, next_state;
  logic                 eff_dir;
  logic                 start, copy_step, clear_step;
  logic                 rd_active, wr_valid;
  logic [ADDR_BITS-1:0] wr_addr_q;
  logic [ADDR_BITS-1:0] copy_dst, copy_src, clear_addr;
  logic                 copy_last, clear_last;

`ifdef SCROLL_ENGINE_DOWN_EN
  assign eff_dir = scroll_dir;
`else
  logic unused_dir;
  assign unused_dir = scroll_dir;
  assign eff_dir    = 1'b0;
`endif

  assign start      = (state == ST_IDLE) && scroll_req;
  assign copy_step  = (state == ST_COPY) && rd_active;
  assign clear_step = (state == ST_CLEAR);

  scroll_addr_gen #(
    .ROWS      (ROWS),
    .COLS      (COLS),
    .ADDR_BITS (ADDR_BITS)
  ) u_addr_gen (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .dir        (eff_dir),
    .copy_step  (copy_step),
    .clear_step (clear_step),
    .copy_dst   (copy_dst),
    .copy_src   (copy_src),
    .copy_last  (copy_last),
    .clear_addr (clear_addr),
    .clear_last (clear_last)
  );

  // Each read's destination is delayed one cycle to line up with the returning data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      rd_active <= 1'b0;
      wr_valid  <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      state     <= next_state;
      wr_valid  <= copy_step;
      wr_addr_q <= copy_dst;
      if (start)
        rd_active <= 1'b1;
      else if (copy_step && copy_last)
        rd_active <= 1'b0;
    end
  end

  always_comb begin
    next_state  = state;
    mem_rd_addr = '0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    mem_wr_en   = 1'b0;
    scroll_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (scroll_req)
          next_state = ST_COPY;
      end
      ST_COPY: begin
        if (copy_step)
          mem_rd_addr = copy_src;
        if (wr_valid) begin
          mem_wr_en   = 1'b1;
          mem_wr_addr = wr_addr_q;
          mem_wr_data = mem_rd_data;
          if (!rd_active)
            next_state = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        mem_wr_en   = 1'b1;
        mem_wr_addr = clear_addr;
        mem_wr_data = FILL_CHAR;
        if (clear_last)
          next_state = ST_DONE;
      end
      ST_DONE: begin
        scroll_done = 1'b1;
        next_state  = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign scroll_busy = (state != ST_IDLE) || scroll_req;
  assign scroll_ovr  = scroll_req && (state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_scroll_engine.sv
// tb_scroll_engine: directed checks of the scroll engine at 24x80 and at 2x3.
`timescale 1ns/1ps
`default_nettype none

module tb_scroll_engine;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        scroll_req = 1'b0;
  logic        scroll_dir = 1'b0;
  logic        scroll_busy, scroll_done, scroll_ovr, mem_wr_en;
  logic [10:0] mem_rd_addr, mem_wr_addr;
  logic [7:0]  mem_rd_data, mem_wr_data;

  logic        s_req = 1'b0;
  logic        s_busy, s_done, s_ovr, s_wr_en;
  logic [3:0]  s_rd_addr, s_wr_addr;
  logic [7:0]  s_rd_data, s_wr_data;

  logic        fill = 1'b0;
  logic [7:0]  mem   [0:2047];
  logic [7:0]  mem_s [0:15];

  int n_pass = 0, n_total = 0;
  int done_cyc, busy_low, n_wr, n_done, ovr_cyc, first_wr, bad;
  logic wr_c1, busy_c0;

  always #5 clk = ~clk;

  scroll_engine dut (
    .clk(clk), .reset_n(reset_n), .scroll_req(scroll_req), .scroll_dir(scroll_dir),
    .scroll_busy(scroll_busy), .scroll_done(scroll_done), .scroll_ovr(scroll_ovr),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en)
  );

  scroll_engine #(.ROWS(2), .COLS(3), .ADDR_BITS(4), .FILL_CHAR(8'h20)) dut_s (
    .clk(clk), .reset_n(reset_n), .scroll_req(s_req), .scroll_dir(1'b0),
    .scroll_busy(s_busy), .scroll_done(s_done), .scroll_ovr(s_ovr),
    .mem_rd_addr(s_rd_addr), .mem_rd_data(s_rd_data),
    .mem_wr_addr(s_wr_addr), .mem_wr_data(s_wr_data), .mem_wr_en(s_wr_en)
  );

  // Synchronous-read buffer models; fill loads byte = row index
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 2048; i++) mem[i] <= (i < 1920) ? 8'(i / 80) : 8'h00;
      for (int i = 0; i < 16; i++)   mem_s[i] <= (i < 6) ? 8'(i / 3) : 8'h00;
    end else begin
      mem_rd_data <= mem[mem_rd_addr];
      s_rd_data   <= mem_s[s_rd_addr];
      if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
      if (s_wr_en)   mem_s[s_wr_addr] <= s_wr_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic prefill();
    @(posedge clk); #1 fill = 1'b1;
    @(posedge clk); #1 fill = 1'b0;
  endtask

  // Request in cycle 0; optional extra request at ovr_at, optional reset at rst_at
  task automatic run(input logic d, input int ovr_at, input int rst_at);
    done_cyc = -1; busy_low = -1; n_wr = 0; n_done = 0; ovr_cyc = -1; first_wr = -1;
    wr_c1 = 1'bx; busy_c0 = 1'bx;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      scroll_req = (c == 0) || (c == ovr_at);
      scroll_dir = d;
      if (c == rst_at) begin
        reset_n = 1'b0;
        #1;
        chk("rst_wr_en_immediate", mem_wr_en, 0);
        chk("rst_busy_drop", scroll_busy, 0);
        break;
      end
      @(negedge clk);
      if (c == 0) busy_c0 = scroll_busy;
      if (c == 1) wr_c1 = mem_wr_en;
      if (mem_wr_en) begin
        n_wr++;
        if (first_wr < 0) first_wr = c;
      end
      if (scroll_done) begin n_done++; done_cyc = c; end
      if (scroll_ovr) ovr_cyc = c;
      if (!scroll_busy && c > 0) begin busy_low = c; break; end
    end
    scroll_req = 1'b0;
    if (busy_low < 0 && rst_at < 0) chk("run_timeout", 1, 0);
  endtask

  task automatic check_up(input string tag);
    bad = 0;
    for (int i = 0; i < 1920; i++)
      if (mem[i] !== ((i / 80 < 23) ? 8'(i / 80 + 1) : 8'h20)) bad++;
    chk(tag, bad, 0);
  endtask

  task automatic check_down(input string tag);
    bad = 0;
    for (int i = 0; i < 1920; i++)
      if (mem[i] !== ((i / 80 > 0) ? 8'(i / 80 - 1) : 8'h20)) bad++;
    chk(tag, bad, 0);
  endtask

  initial begin
    #2;
    chk("reset_busy", scroll_busy, 0);
    chk("reset_done", scroll_done, 0);
    chk("reset_ovr", scroll_ovr, 0);
    chk("reset_wr_en", mem_wr_en, 0);
    chk("reset_rd_addr", mem_rd_addr, 0);
    chk("reset_wr_addr", mem_wr_addr, 0);
    chk("reset_wr_data", mem_wr_data, 0);
    #20 reset_n = 1'b1;

    // Up scroll, full timing
    prefill();
    run(1'b0, -1, -1);
    chk("up_busy_cycle0", busy_c0, 1);
    chk("up_wr_en_cycle1", wr_c1, 0);
    chk("up_first_write_cycle", first_wr, 2);
    chk("up_done_cycle", done_cyc, 1922);
    chk("up_done_count", n_done, 1);
    chk("up_busy_low_cycle", busy_low, 1923);
    chk("up_write_count", n_wr, 1920);
    check_up("up_buffer");
    chk("up_row0_byte", mem[0], 8'h01);
    chk("up_row23_byte", mem[1919], 8'h20);

    // dir=1: down scroll only when the feature is built in
    prefill();
    run(1'b1, -1, -1);
    chk("dn_done_cycle", done_cyc, 1922);
    chk("dn_write_count", n_wr, 1920);
`ifdef SCROLL_ENGINE_DOWN_EN
    check_down("dn_buffer");
`else
    check_up("dn_ignored_buffer");
`endif

    // Overlapping request at cycle 500
    prefill();
    run(1'b0, 500, -1);
    chk("ovr_cycle", ovr_cyc, 500);
    chk("ovr_done_count", n_done, 1);
    chk("ovr_busy_low_cycle", busy_low, 1923);
    check_up("ovr_buffer");

    // Reset in the middle of a copy
    prefill();
    run(1'b0, -1, 900);
    n_wr = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (mem_wr_en || scroll_busy) n_wr++;
    end
    chk("rst_quiet_cycles", n_wr, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    prefill();
    run(1'b0, -1, -1);
    chk("rst_rerun_done_cycle", done_cyc, 1922);
    check_up("rst_rerun_buffer");

    // Small geometry 2x3
    done_cyc = -1; n_wr = 0; bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1 s_req = (c == 0);
      @(negedge clk);
      if (s_wr_en) begin
        n_wr++;
        if (s_wr_data === 8'h20) bad++;
      end
      if (s_done) done_cyc = c;
      if (!s_busy && c > 0) break;
    end
    s_req = 1'b0;
    chk("small_total_writes", n_wr, 6);
    chk("small_clear_writes", bad, 3);
    chk("small_done_cycle", done_cyc, 8);
    chk("small_row0", {mem_s[0], mem_s[1], mem_s[2]}, 24'h010101);
    chk("small_row1", {mem_s[3], mem_s[4], mem_s[5]}, 24'h202020);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/scroll_engine.md
SCROLL_ENGINE -- requirements
Module: scroll_engine

Interface
REQ-001 Parameter ROWS, default 24, visible text rows.
REQ-002 Parameter COLS, default 80, characters per row.
REQ-003 Parameter ADDR_BITS, default 11, character-buffer address width.
REQ-004 Parameter FILL_CHAR, default 8'h20, byte written into the vacated row.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low; ports clk and reset_n.
REQ-006 clk  input  1  system clock.
REQ-007 reset_n  input  1  asynchronous active-low reset.
REQ-008 scroll_req  input  1  one-cycle scroll request pulse from the command handler's buffer_scroll.
REQ-009 scroll_dir  input  1  0 = scroll up (text moves toward row 0), 1 = scroll down; sampled with scroll_req.
REQ-010 scroll_busy  output  1  operation in progress; goes to the command handler.
REQ-011 scroll_done  output  1  one-cycle pulse at completion.
REQ-012 scroll_ovr  output  1  one-cycle pulse when a request is dropped.
REQ-013 mem_rd_addr  output  ADDR_BITS  character-buffer read address; data returns one cycle later.
REQ-014 mem_rd_data  input  8  read data for the address presented the previous cycle.
REQ-015 mem_wr_addr  output  ADDR_BITS  character-buffer write address.
REQ-016 mem_wr_data  output  8  character-buffer write data.
REQ-017 mem_wr_en  output  1  write strobe, one write per cycle.

Function
REQ-018 States: IDLE, COPY, CLEAR, DONE; IDLE->COPY on scroll_req; COPY->CLEAR after the final copy write; CLEAR->DONE after the final clear write; DONE->IDLE unconditionally.
REQ-019 scroll_busy shall equal (state != IDLE) OR scroll_req (combinational term), so it is high in the request cycle itself.
REQ-020 Cycle numbering: the request is seen in cycle 0; the first read address is presented in cycle 1.
REQ-021 Up scroll: destination addresses run ascending from 0 to (ROWS-1)*COLS-1, each with source = destination+COLS; clear addresses run ascending from (ROWS-1)*COLS to ROWS*COLS-1.
REQ-022 Down scroll: destination addresses run descending from ROWS*COLS-1 to COLS, each with source = destination-COLS; clear addresses run descending from COLS-1 to 0.
REQ-023 COPY shall be pipelined: one read per cycle; the write of mem_rd_data to the matching destination occurs the cycle after its read.
REQ-024 Copy writes fall in cycles 2..(ROWS-1)*COLS+1; clear writes with FILL_CHAR fall in the next COLS cycles.
REQ-025 scroll_done pulses in cycle ROWS*COLS+2 (1922 at 24x80); scroll_busy is low from cycle ROWS*COLS+3.
REQ-026 mem_wr_en shall be low in IDLE, in DONE, and in cycle 1.
REQ-027 A scroll_req while state != IDLE shall be ignored and shall pulse scroll_ovr in the same cycle.
REQ-028 Address arithmetic shall be ADDR_BITS wide; counters shall never exceed ROWS*COLS-1, and the down-scroll counter shall never underflow.

Reset
REQ-029 On reset_n low, state = IDLE immediately, any operation aborts, and no further writes occur.
REQ-030 Reset values of all outputs are 0, except that scroll_busy follows REQ-019.

Configuration
REQ-031 Macro SCROLL_ENGINE_DOWN_EN: when defined, scroll_dir=1 selects down scroll.
REQ-032 When SCROLL_ENGINE_DOWN_EN is undefined, scroll_dir is ignored and every request performs an up scroll.

Structure
REQ-033 Package vt52_pkg shall hold ROWS, COLS, ADDR_BITS, FILL_CHAR defaults and the scroll state enum typedef.
REQ-034 Sub-module scroll_addr_gen (up/down source and destination counters with terminal flags) shall be used; all else is inline.

Verification
REQ-035 Prefilled buffer (byte = row index), pulse scroll_req with dir=0 -> row r holds r+1 for r<23, row 23 is all 8'h20, scroll_done pulses at cycle 1922.
REQ-036 Same prefill, dir=1 with SCROLL_ENGINE_DOWN_EN defined -> row r holds r-1 for r>0, row 0 is all 8'h20; without the macro -> up-scroll result.
REQ-037 Request in cycle 0 -> scroll_busy is high in cycle 0 and low from cycle 1923.
REQ-038 Second scroll_req at cycle 500 -> scroll_ovr pulses at cycle 500, a single scroll is performed, and there is one scroll_done.
REQ-039 Assert reset_n low at cycle 900 -> mem_wr_en is 0 immediately, scroll_busy drops, and a new request after release completes normally.
REQ-040 Small parameters ROWS=2, COLS=3 -> exactly 3 copy writes plus 3 clear writes, and scroll_done at cycle 8.
